// File: rtl/sequence_player.sv
// LED sequencer playback engine: steps through pattern memory one address per
// div_clk edge and presents each step's pattern on led, one edge behind r_addr.
module sequence_player #(
    parameter int MEM_WIDTH  = 2,
    parameter int NUM_STEPS  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  div_clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  loop,
    input  logic                  restart,
    input  logic [ADDR_WIDTH:0]   seq_len,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [MEM_WIDTH-1:0]  r_data,
    output logic [MEM_WIDTH-1:0]  led,
    output logic [ADDR_WIDTH-1:0] step_idx,
    output logic                  playing,
    output logic                  done,
    output logic                  wrapped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(NUM_STEPS);

    state_e                state_q, state_d;
    logic                  r_en_q, r_en_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [MEM_WIDTH-1:0]  led_q, led_d;
    logic [ADDR_WIDTH-1:0] step_idx_q, step_idx_d;
    logic                  playing_q, playing_d;
    logic                  done_q, done_d;
    logic                  wrapped_q, wrapped_d;

    logic [ADDR_WIDTH:0]   len_c;
    logic [ADDR_WIDTH:0]   addr_inc;

    always_comb begin
        len_c    = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
        // One extra bit so the last-step compare cannot overflow at NUM_STEPS.
        addr_inc = {1'b0, r_addr_q} + (ADDR_WIDTH + 1)'(1);

        state_d    = state_q;
        r_en_d     = r_en_q;
        r_addr_d   = r_addr_q;
        led_d      = led_q;
        step_idx_d = step_idx_q;
        wrapped_d  = 1'b0;

        if (restart) begin
            state_d    = S_IDLE;
            led_d      = '0;
            r_en_d     = 1'b0;
            r_addr_d   = '0;
            step_idx_d = '0;
        end else if (len_c == '0) begin
            state_d = S_IDLE;
            led_d   = '0;
            r_en_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    led_d = '0;
                    if (en) begin
                        r_addr_d = '0;
                        r_en_d   = 1'b1;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        led_d      = r_data;
                        step_idx_d = r_addr_q;
                        if (addr_inc < len_c) begin
                            r_addr_d = addr_inc[ADDR_WIDTH-1:0];
                        end else if (loop) begin
                            r_addr_d  = '0;
                            wrapped_d = 1'b1;
                        end else begin
                            r_en_d  = 1'b0;
                            state_d = S_DONE;
                        end
                    end else begin
                        // r_addr is the fetch not yet shown; it is re-read on resume.
                        r_en_d  = 1'b0;
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (en) begin
                        r_en_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (!en) begin
                        led_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        playing_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            r_en_q     <= 1'b0;
            r_addr_q   <= '0;
            led_q      <= '0;
            step_idx_q <= '0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_en_q     <= r_en_d;
            r_addr_q   <= r_addr_d;
            led_q      <= led_d;
            step_idx_q <= step_idx_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign r_en     = r_en_q;
    assign r_addr   = r_addr_q;
    assign led      = led_q;
    assign step_idx = step_idx_q;
    assign playing  = playing_q;
    assign done     = done_q;
    assign wrapped  = wrapped_q;

endmodule
